// File: rtl/mem_addr_arbiter_pkg.sv
// Shared constants for the DLX memory-address arbiter: FSM encodings,
// address-mux select values and the round-robin grant helper.
package mem_addr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic SEL_I  = 1'b0;
  localparam logic SEL_D  = 1'b1;
  localparam int   ADDR_W = 16;

  // On a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic i_req, input logic d_req,
                                   input logic last_gnt);
    if (i_req && d_req) return ~last_gnt;
    if (d_req)          return SEL_D;
    return SEL_I;
  endfunction

endpackage

// File: rtl/mem_addr_arbiter_mux.sv
// 16-bit 2:1 address mux selecting the fetch (PC) or data (MAR) address.
module mem_addr_arbiter_mux
  import mem_addr_arbiter_pkg::*;
(
  input  logic              sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [ADDR_W-1:0] addr
);

  assign addr = (sel == SEL_D) ? d_addr : i_addr;

endmodule

// File: rtl/mem_addr_arbiter.sv
// Arbitrates instruction-fetch and data accesses onto one memory port with
// round-robin tie breaking and a bounded wait for memory ready.
module mem_addr_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic              addr_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_rdy,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic              last_gnt;
  logic              grant_sel;
  logic              mux_sel;
  logic [ADDR_W-1:0] mux_addr;
  logic              wait_expired;

  assign grant_sel    = rr_pick(i_req, d_req, last_gnt);
  // While idle the mux follows the pending grant so the address latches on the grant edge.
  assign mux_sel      = (state == ST_IDLE) ? grant_sel : addr_sel;
  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign wait_expired = (wait_cnt_inc == CNT_W'(TIMEOUT_CYC));

  mem_addr_arbiter_mux u_addr_mux (
    .sel    (mux_sel),
    .i_addr (i_addr),
    .d_addr (d_addr),
    .addr   (mux_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      addr_sel <= SEL_I;
      mem_addr <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
      last_gnt <= SEL_D;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            mem_addr <= mux_addr;
            addr_sel <= grant_sel;
            mem_req  <= 1'b1;
            mem_we   <= (grant_sel == SEL_D) && d_we;
            wait_cnt <= '0;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!mem_rdy) wait_cnt <= wait_cnt_inc;
          if (mem_rdy || wait_expired) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            i_ack    <= (addr_sel == SEL_I);
            d_ack    <= (addr_sel == SEL_D);
            last_gnt <= addr_sel;
            // A ready arriving on the expiry edge counts as a normal completion.
            if (!mem_rdy) timeout <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
